// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared next-PC select codes, fetch FSM encoding and NOP word
package ifetch_pkg;

  localparam logic [1:0] NPC_PC4    = 2'd0;
  localparam logic [1:0] NPC_BRANCH = 2'd1;
  localparam logic [1:0] NPC_JAL    = 2'd2;
  localparam logic [1:0] NPC_JALR   = 2'd3;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HALT  = 2'd2
  } ifetch_state_e;

endpackage

// File: rtl/ifetch_npc.sv
// rtl/ifetch_npc.sv - combinational next-PC select and alignment check
module ifetch_npc
  import ifetch_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [1:0]  npc_op_i,
  input  logic        br_taken_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] alu_c_i,
  output logic [31:0] next_pc_o,
  output logic        misalign_o
);

  always_comb begin
    next_pc_o = pc_i + 32'd4;
    unique case (npc_op_i)
      NPC_PC4:    next_pc_o = pc_i + 32'd4;
      NPC_BRANCH: next_pc_o = br_taken_i ? (pc_i + imm_i) : (pc_i + 32'd4);
      NPC_JAL:    next_pc_o = pc_i + imm_i;
      NPC_JALR:   next_pc_o = alu_c_i & ~32'h1;
      default:    next_pc_o = pc_i + 32'd4;
    endcase
    // JALR bit 0 is already cleared, so only a genuine bad target trips this
    misalign_o = |next_pc_o[1:0];
  end

endmodule

// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch stage: PC register, imem req/ack fetch, issue to decode
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 14,
  parameter logic [31:0] NOP      = NOP_INSTR
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         npc_op_i,
  input  logic               br_taken_i,
  input  logic [31:0]        sext_ext_i,
  input  logic [31:0]        alu_c_i,
  input  logic               stall_i,
  output logic               imem_req_o,
  output logic [IMEM_AW-1:0] imem_addr_o,
  input  logic [31:0]        imem_rdata_i,
  input  logic               imem_ack_i,
  output logic               inst_valid_o,
  output logic [31:0]        instruction_o,
  output logic [31:0]        pc_o,
  output logic [31:0]        npc_pc4_o,
  output logic               misalign_o
);

  ifetch_state_e state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   instr_q, instr_d;
  logic          req_q, req_d;
  logic          valid_q, valid_d;
  logic          misalign_q, misalign_d;

  logic [31:0]   next_pc;
  logic          next_misalign;

  ifetch_npc u_npc (
    .pc_i       (pc_q),
    .npc_op_i   (npc_op_i),
    .br_taken_i (br_taken_i),
    .imm_i      (sext_ext_i),
    .alu_c_i    (alu_c_i),
    .next_pc_o  (next_pc),
    .misalign_o (next_misalign)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    req_d      = req_q;
    valid_d    = valid_q;
    misalign_d = misalign_q;
    case (state_q)
      ST_FETCH: begin
        if (imem_ack_i) begin
          instr_d = imem_rdata_i;
          state_d = ST_ISSUE;
          req_d   = 1'b0;
          valid_d = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (!stall_i) begin
          valid_d = 1'b0;
          if (next_misalign) begin
            // Park with the faulting PC visible; only reset leaves HALT
            state_d    = ST_HALT;
            misalign_d = 1'b1;
          end else begin
            pc_d    = next_pc;
            instr_d = NOP;
            state_d = ST_FETCH;
            req_d   = 1'b1;
          end
        end
      end
      default: begin
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= NOP;
      req_q      <= 1'b1;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      req_q      <= req_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
    end
  end

  assign imem_req_o    = req_q;
  assign imem_addr_o   = pc_q[IMEM_AW+1:2];
  assign inst_valid_o  = valid_q;
  assign instruction_o = instr_q;
  assign pc_o          = pc_q;
  assign npc_pc4_o     = pc_q + 32'd4;
  assign misalign_o    = misalign_q;

endmodule

// File: tb/tb_ifetch.sv
// tb/tb_ifetch.sv - self-checking bench for ifetch against a PC-level reference model
module tb_ifetch;
  import ifetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          AW     = 14;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    npc_op_i;
  logic          br_taken_i;
  logic [31:0]   sext_ext_i;
  logic [31:0]   alu_c_i;
  logic          stall_i;
  logic          imem_req_o;
  logic [AW-1:0] imem_addr_o;
  logic [31:0]   imem_rdata_i;
  logic          imem_ack_i;
  logic          inst_valid_o;
  logic [31:0]   instruction_o;
  logic [31:0]   pc_o;
  logic [31:0]   npc_pc4_o;
  logic          misalign_o;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_pc;
  logic [31:0] exp_instr;
  logic        exp_halt;

  ifetch #(.RESET_PC(RST_PC), .IMEM_AW(AW), .NOP(NOP_INSTR)) dut (
    .clk           (clk),
    .reset         (reset),
    .npc_op_i      (npc_op_i),
    .br_taken_i    (br_taken_i),
    .sext_ext_i    (sext_ext_i),
    .alu_c_i       (alu_c_i),
    .stall_i       (stall_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_rdata_i  (imem_rdata_i),
    .imem_ack_i    (imem_ack_i),
    .inst_valid_o  (inst_valid_o),
    .instruction_o (instruction_o),
    .pc_o          (pc_o),
    .npc_pc4_o     (npc_pc4_o),
    .misalign_o    (misalign_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_target(input logic [31:0] pc, input logic [1:0] op,
                                             input logic br, input logic [31:0] imm,
                                             input logic [31:0] alu);
    if (op == 2'd0)      return pc + 4;
    else if (op == 2'd1) return br ? pc + imm : pc + 4;
    else if (op == 2'd2) return pc + imm;
    else                 return {alu[31:1], 1'b0};
  endfunction

  task automatic scramble_ignored();
    npc_op_i   = 2'($urandom_range(0, 3));
    br_taken_i = 1'($urandom_range(0, 1));
    sext_ext_i = $urandom;
    alu_c_i    = $urandom;
  endtask

  task automatic check_reset_values();
    check("rst_pc", pc_o, RST_PC);
    check("rst_pc4", npc_pc4_o, RST_PC + 4);
    check("rst_instr", instruction_o, NOP_INSTR);
    check("rst_valid", {31'd0, inst_valid_o}, 32'd0);
    check("rst_req", {31'd0, imem_req_o}, 32'd1);
    check("rst_addr", {18'd0, imem_addr_o}, {18'd0, RST_PC[AW+1:2]});
    check("rst_misalign", {31'd0, misalign_o}, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    imem_ack_i = 1'b0;
    step();
    check_reset_values();
    reset = 1'b0;
    exp_pc = RST_PC;
    exp_instr = NOP_INSTR;
    exp_halt = 1'b0;
  endtask

  // Memory answers after lat idle cycles; request and address must hold meanwhile
  task automatic fetch(input int lat, input logic [31:0] word);
    for (int i = 0; i <= lat; i++) begin
      check("f_req", {31'd0, imem_req_o}, 32'd1);
      check("f_addr", {18'd0, imem_addr_o}, {18'd0, exp_pc[AW+1:2]});
      check("f_valid", {31'd0, inst_valid_o}, 32'd0);
      check("f_pc", pc_o, exp_pc);
      check("f_pc4", npc_pc4_o, exp_pc + 4);
      scramble_ignored();
      stall_i = 1'($urandom_range(0, 1));
      imem_ack_i   = (i == lat);
      imem_rdata_i = (i == lat) ? word : $urandom;
      step();
    end
    imem_ack_i   = 1'b0;
    imem_rdata_i = $urandom;
    exp_instr    = word;
    check("i_valid", {31'd0, inst_valid_o}, 32'd1);
    check("i_instr", instruction_o, word);
    check("i_req", {31'd0, imem_req_o}, 32'd0);
    check("i_pc", pc_o, exp_pc);
  endtask

  task automatic issue(input int stalls, input logic [1:0] op, input logic br,
                       input logic [31:0] imm, input logic [31:0] alu);
    logic [31:0] tgt;
    for (int i = 0; i < stalls; i++) begin
      stall_i = 1'b1;
      scramble_ignored();
      imem_ack_i   = 1'($urandom_range(0, 1));
      imem_rdata_i = $urandom;
      step();
      check("s_valid", {31'd0, inst_valid_o}, 32'd1);
      check("s_instr", instruction_o, exp_instr);
      check("s_pc", pc_o, exp_pc);
      check("s_req", {31'd0, imem_req_o}, 32'd0);
    end
    stall_i    = 1'b0;
    imem_ack_i = 1'b0;
    npc_op_i   = op;
    br_taken_i = br;
    sext_ext_i = imm;
    alu_c_i    = alu;
    step();
    scramble_ignored();
    tgt = ref_target(exp_pc, op, br, imm, alu);
    if (tgt[1:0] != 2'b00) begin
      exp_halt = 1'b1;
      check("h_misalign", {31'd0, misalign_o}, 32'd1);
      check("h_valid", {31'd0, inst_valid_o}, 32'd0);
      check("h_req", {31'd0, imem_req_o}, 32'd0);
      check("h_pc", pc_o, exp_pc);
    end else begin
      exp_pc = tgt;
      check("r_pc", pc_o, exp_pc);
      check("r_pc4", npc_pc4_o, exp_pc + 4);
      check("r_valid", {31'd0, inst_valid_o}, 32'd0);
      check("r_req", {31'd0, imem_req_o}, 32'd1);
      check("r_addr", {18'd0, imem_addr_o}, {18'd0, exp_pc[AW+1:2]});
      check("r_instr", instruction_o, NOP_INSTR);
      check("r_misalign", {31'd0, misalign_o}, 32'd0);
    end
  endtask

  task automatic halt_hold(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      scramble_ignored();
      stall_i      = 1'($urandom_range(0, 1));
      imem_ack_i   = 1'($urandom_range(0, 1));
      imem_rdata_i = $urandom;
      step();
      check("hh_req", {31'd0, imem_req_o}, 32'd0);
      check("hh_valid", {31'd0, inst_valid_o}, 32'd0);
      check("hh_misalign", {31'd0, misalign_o}, 32'd1);
      check("hh_pc", pc_o, exp_pc);
    end
    imem_ack_i = 1'b0;
  endtask

  initial begin
    logic [1:0]  op;
    logic        br;
    logic [31:0] imm;
    logic [31:0] alu;

    reset = 1'b1; stall_i = 1'b0; imem_ack_i = 1'b0; imem_rdata_i = 32'd0;
    npc_op_i = NPC_PC4; br_taken_i = 1'b0; sext_ext_i = 32'd0; alu_c_i = 32'd0;
    exp_pc = RST_PC; exp_instr = NOP_INSTR; exp_halt = 1'b0;
    step();
    do_reset();

    // zero-wait sequential fetch: 0, 4, 8
    fetch(0, 32'h0050_0093); issue(0, NPC_PC4, 1'b0, 32'd0, 32'd0);
    fetch(0, $urandom);      issue(0, NPC_PC4, 1'b0, 32'd0, 32'd0);
    check("seq_pc8", pc_o, 32'h8);

    // slow memory, then jump to 0x100
    fetch(3, 32'hDEAD_BEEF); issue(0, NPC_JAL, 1'b0, 32'h0000_00F8, 32'd0);
    fetch(0, $urandom); issue(5, NPC_BRANCH, 1'b1, 32'hFFFF_FFF8, 32'd0);
    check("br_taken", pc_o, 32'hF8);
    fetch(1, $urandom); issue(0, NPC_JAL, 1'b0, 32'd8, 32'd0);
    fetch(0, $urandom); issue(2, NPC_BRANCH, 1'b0, 32'hFFFF_FFF8, 32'd0);
    check("br_not_taken", pc_o, 32'h104);
    fetch(0, $urandom); issue(0, NPC_JAL, 1'b0, 32'hFFFF_FFFC, 32'd0);
    fetch(2, $urandom); issue(0, NPC_JAL, 1'b0, 32'h20, 32'd0);
    check("jal", pc_o, 32'h120);
    fetch(0, $urandom); issue(0, NPC_JALR, 1'b0, 32'd0, 32'h2001);
    check("jalr_bit0", pc_o, 32'h2000);
    fetch(0, $urandom); issue(0, NPC_JALR, 1'b0, 32'd0, 32'h100);
    fetch(0, $urandom); issue(1, NPC_JALR, 1'b0, 32'd0, 32'h2002);
    check("halt_flag", {31'd0, exp_halt}, {31'd0, misalign_o});
    halt_hold(5);
    do_reset();

    // reset abandons an in-flight fetch
    imem_ack_i = 1'b0;
    step(); step();
    do_reset();

    // PC wraps modulo 2^32
    fetch(0, $urandom); issue(0, NPC_JALR, 1'b0, 32'd0, 32'hFFFF_FFFD);
    check("pc_top", pc_o, 32'hFFFF_FFFC);
    fetch(1, $urandom); issue(0, NPC_PC4, 1'b0, 32'd0, 32'd0);
    check("pc_wrap", pc_o, 32'h0);

    for (int n = 0; n < 60; n++) begin
      op  = 2'($urandom_range(0, 3));
      br  = 1'($urandom_range(0, 1));
      imm = 32'(($urandom_range(0, 127) - 64) * 4);
      alu = $urandom & ~32'h3;
      if ($urandom_range(0, 7) == 0) imm = imm | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) alu = alu | 32'($urandom_range(1, 3));
      fetch($urandom_range(0, 3), $urandom);
      issue($urandom_range(0, 2), op, br, imm, alu);
      if (exp_halt) begin
        halt_hold(2);
        do_reset();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch stage of the single-cycle RISC-V core, directly upstream of the decode stage (register file, sign extension, write-data select). Holds the PC, fetches from instruction memory over a req/ack handshake, and presents a valid 32-bit instruction plus PC+4 to decode. Computes the next PC from the decode/execute results (branch, JAL, JALR) when the core releases the current instruction.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned
- IMEM_AW, 14, instruction memory word-address width
- NOP, 32'h0000_0013, value of instruction_o while no instruction is valid

- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- npc_op_i  in  2  next-PC select: 0 PC+4, 1 branch, 2 JAL, 3 JALR
- br_taken_i  in  1  branch condition from ALU; used only when npc_op_i=1
- sext_ext_i  in  32  sign-extended immediate from decode
- alu_c_i  in  32  ALU result; JALR target
- stall_i  in  1  core not ready to retire current instruction
- imem_req_o  out  1  fetch request
- imem_addr_o  out  IMEM_AW  word address = pc[IMEM_AW+1:2]
- imem_rdata_i  in  32  instruction word, sampled when imem_ack_i=1
- imem_ack_i  in  1  memory response valid
- inst_valid_o  out  1  instruction_o is valid for execution
- instruction_o  out  32  current instruction (registered)
- pc_o  out  32  PC of current instruction
- npc_pc4_o  out  32  pc_o + 4, to write-data select for JAL/JALR
- misalign_o  out  1  sticky: misaligned next-PC target detected

## Operation
- FSM states: FETCH, ISSUE, HALT.
- FETCH: imem_req_o=1, imem_addr_o stable until ack; inst_valid_o=0. On imem_ack_i=1: instruction register <= imem_rdata_i, go ISSUE.
- ISSUE: imem_req_o=0, inst_valid_o=1, instruction_o held. stall_i=1: hold everything. stall_i=0: compute next PC; if next[1:0]!=0 go HALT, set misalign_o, pc unchanged; else pc <= next, instruction register <= NOP, go FETCH.
- HALT: imem_req_o=0, inst_valid_o=0; remains until reset.
- Next PC: op0 pc+4; op1 br_taken_i ? pc+sext_ext_i : pc+4; op2 pc+sext_ext_i; op3 alu_c_i & ~32'h1. Misalignment checked after JALR bit-0 clear.
- All PC arithmetic modulo 2^32: pc=32'hFFFF_FFFC with op0 → 0, no error.
- imem_ack_i outside FETCH is ignored. npc_op_i, br_taken_i, sext_ext_i, alu_c_i ignored outside ISSUE with stall_i=0.

## Timing
- Reset values (cycle after reset high): state FETCH, pc_o=RESET_PC, npc_pc4_o=RESET_PC+4, instruction_o=NOP, inst_valid_o=0, imem_req_o=1, imem_addr_o=RESET_PC[IMEM_AW+1:2], misalign_o=0.
- Reset overrides every state including mid-fetch and HALT; pending request abandoned. Instruction memory shares reset, so no stale ack follows.
- Ack in cycle N → inst_valid_o=1 in N+1. Zero-wait memory (ack same cycle as req): 2 cycles per instruction.
- Retire edge (ISSUE, stall_i=0): pc_o updates and inst_valid_o drops in the same following cycle; imem_req_o=1 with new address that cycle.
- imem_req_o, imem_addr_o, inst_valid_o, misalign_o are decoded from registered state/pc only; no combinational path from any input.

## Structure
- Package ifetch_pkg: NPC_PC4/NPC_BRANCH/NPC_JAL/NPC_JALR 2-bit constants, FSM state encoding, NOP constant; shared with the controller that drives npc_op_i.
- Sub-module npc: purely combinational next-PC and misalign computation (pc, npc_op, br_taken, imm, alu_c → next, misalign). FSM and registers stay in ifetch.

## Test plan
- Reset, zero-wait memory returning 32'h00500093 at word 0, stall_i=0, op0 → inst_valid_o every 2nd cycle, pc_o 0,4,8; npc_pc4_o = pc_o+4.
- Memory ack delayed 3 cycles → imem_addr_o stable and req high for 4 cycles; inst_valid_o rises exactly 1 cycle after ack; instruction_o = returned word.
- pc=0x100, op1, sext=-8: br_taken_i=1 → next pc 0xF8; br_taken_i=0 → 0x104. op2 sext=0x20 → 0x120. op3 alu_c=0x2001 → 0x2000, no error.
- op3 alu_c=0x2002 → HALT, misalign_o=1, pc_o stays 0x100, req stays 0 until reset; reset → pc_o=RESET_PC, misalign_o=0.
- stall_i=1 for 5 cycles in ISSUE → outputs frozen; spurious imem_ack_i during ISSUE ignored; reset asserted mid-FETCH → reset values next cycle.
- pc=0xFFFFFFFC, op0 → pc_o=0, misalign_o=0.
